// File: rtl/arbiter_requester_if.sv
// rtl/arbiter_requester_if.sv - job push, arbiter handshake and status bundle for arbiter_requester
interface arbiter_requester_if;
    logic       job_valid;
    logic [3:0] job_len;
    logic       job_ready;
    logic       g;
    logic       r;
    logic       beat;
    logic       done;
    logic       timeout;
    logic       error;
    logic       busy;
    logic [1:0] req_state;

    // Environment side: pushes jobs and plays the arbiter grant
    modport master (
        output job_valid, job_len, g,
        input  job_ready, r, beat, done, timeout, error, busy, req_state
    );

    // Requester side
    modport slave (
        input  job_valid, job_len, g,
        output job_ready, r, beat, done, timeout, error, busy, req_state
    );
endinterface

// File: rtl/arbiter_requester.sv
// rtl/arbiter_requester.sv - queued burst requester with grant timeout, retry and drop
module arbiter_requester #(
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd15,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    arbiter_requester_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_XFER = 2'b10,
        ST_REL  = 2'b11
    } state_e;

    state_e     state_q;
    logic [3:0] fifo_q [4];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] count_q;
    logic [2:0] count_d;
    logic [3:0] beats_q;
    logic [7:0] wait_q;
    logic [7:0] retry_q;
    logic       retry_pend_q;

    logic full;
    logic push;
    logic pop;
    logic beat_w;
    logic last_w;
    logic tmo_w;
    logic drop_w;

    // Queue handshake and event decodes; all derived from registered state plus g
    always_comb begin
        full   = (count_q == 3'd4);
        push   = bus.job_valid && !full;
        pop    = (state_q == ST_IDLE) && (count_q != 3'd0);
        beat_w = (state_q == ST_XFER) && bus.g;
        last_w = beat_w && (beats_q == 4'd1);
        tmo_w  = (state_q == ST_REQ) && !bus.g && (wait_q == TIMEOUT_CYCLES - 8'd1);
        drop_w = tmo_w && (retry_q == 8'(MAX_RETRIES - 1));
    end

    // Occupancy: a push and a pop in the same cycle cancel out
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Queue storage needs no reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= bus.job_len;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_d;
        end
    end

    // Request FSM with beat, wait and retry counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            beats_q      <= 4'd0;
            wait_q       <= 8'd0;
            retry_q      <= 8'd0;
            retry_pend_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        beats_q      <= fifo_q[rd_ptr_q];
                        wait_q       <= 8'd0;
                        retry_q      <= 8'd0;
                        retry_pend_q <= 1'b0;
                        state_q      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.g) begin
                        wait_q  <= 8'd0;
                        state_q <= ST_XFER;
                    end else if (tmo_w) begin
                        retry_q      <= retry_q + 8'd1;
                        retry_pend_q <= !drop_w;
                        state_q      <= ST_REL;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                ST_XFER: begin
                    // A withdrawn grant simply stalls here; no timeout applies
                    if (bus.g) begin
                        beats_q <= beats_q - 4'd1;
                        if (last_w) begin
                            state_q <= ST_REL;
                        end
                    end
                end
                default: begin
                    // One cycle with r low lets the arbiter fall back to idle
                    wait_q       <= 8'd0;
                    retry_pend_q <= 1'b0;
                    state_q      <= retry_pend_q ? ST_REQ : ST_IDLE;
                end
            endcase
        end
    end

    assign bus.job_ready = !full;
    assign bus.r         = (state_q == ST_REQ) || (state_q == ST_XFER);
    assign bus.beat      = beat_w;
    assign bus.done      = last_w;
    assign bus.timeout   = tmo_w;
    assign bus.error     = drop_w;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.req_state = state_q;
endmodule

// File: tb/tb_arbiter_requester.sv
// tb/tb_arbiter_requester.sv - directed self-checking bench for arbiter_requester
module tb_arbiter_requester;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_REQ  = 2'b01;
    localparam logic [1:0] S_XFER = 2'b10;
    localparam logic [1:0] S_REL  = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic g_follow = 1'b0;
    logic g_man = 1'b0;
    logic g_del;
    int   errors = 0;
    int   checks = 0;
    int   beats;
    int   dones;

    always #5 clk = ~clk;

    arbiter_requester_if bus ();

    arbiter_requester #(
        .TIMEOUT_CYCLES (8'd15),
        .MAX_RETRIES    (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Arbiter model for the "grant follows request by one cycle" case
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) g_del <= 1'b0;
        else        g_del <= bus.r;
    end

    assign bus.g = g_follow ? g_del : g_man;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle at the falling edge, then move to just after the next rising edge
    task automatic chk_cyc(input string tag, input logic [1:0] st, input logic bt,
                           input logic dn, input logic to, input logic er);
        @(negedge clk);
        chk({tag, ".state"},   8'(bus.req_state), 8'(st));
        chk({tag, ".r"},       8'(bus.r),         8'((st == S_REQ) || (st == S_XFER)));
        chk({tag, ".busy"},    8'(bus.busy),      8'(st != S_IDLE));
        chk({tag, ".beat"},    8'(bus.beat),      8'(bt));
        chk({tag, ".done"},    8'(bus.done),      8'(dn));
        chk({tag, ".timeout"}, 8'(bus.timeout),   8'(to));
        chk({tag, ".error"},   8'(bus.error),     8'(er));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lens [5];
        lens = '{2, 3, 4, 5, 7};
        bus.job_valid = 1'b0;
        bus.job_len   = 4'd0;
        g_man         = 1'b1;

        // Reset state, with a stray grant present
        #2;
        chk("rst.state", 8'(bus.req_state), 8'(S_IDLE));
        chk("rst.r",     8'(bus.r),         8'd0);
        chk("rst.beat",  8'(bus.beat),      8'd0);
        chk("rst.busy",  8'(bus.busy),      8'd0);
        chk("rst.ready", 8'(bus.job_ready), 8'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_cyc("rst_rel", S_IDLE, 0, 0, 0, 0);
        g_man = 1'b0;

        // len=3, grant trails request by one cycle
        g_follow = 1'b1;
        bus.job_valid = 1'b1; bus.job_len = 4'd3;
        chk("t1.ready", 8'(bus.job_ready), 8'd1);
        chk_cyc("t1.push", S_IDLE, 0, 0, 0, 0);
        bus.job_valid = 1'b0;
        chk_cyc("t1.pop",  S_IDLE, 0, 0, 0, 0);
        chk_cyc("t1.req0", S_REQ,  0, 0, 0, 0);
        chk_cyc("t1.req1", S_REQ,  0, 0, 0, 0);
        chk_cyc("t1.b1",   S_XFER, 1, 0, 0, 0);
        chk_cyc("t1.b2",   S_XFER, 1, 0, 0, 0);
        chk_cyc("t1.b3",   S_XFER, 1, 1, 0, 0);
        chk_cyc("t1.rel",  S_REL,  0, 0, 0, 0);
        chk_cyc("t1.idle", S_IDLE, 0, 0, 0, 0);
        g_follow = 1'b0;

        // len=0 means 16 beats; grant held high throughout, ignored in IDLE/RELEASE
        g_man = 1'b1;
        bus.job_valid = 1'b1; bus.job_len = 4'd0;
        chk_cyc("t2.push", S_IDLE, 0, 0, 0, 0);
        bus.job_valid = 1'b0;
        chk_cyc("t2.pop",  S_IDLE, 0, 0, 0, 0);
        chk_cyc("t2.req",  S_REQ,  0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            chk_cyc($sformatf("t2.b%0d", i + 1), S_XFER, 1, 8'(i == 15) != 0, 0, 0);
        end
        chk_cyc("t2.rel",  S_REL,  0, 0, 0, 0);
        chk_cyc("t2.idle", S_IDLE, 0, 0, 0, 0);
        g_man = 1'b0;

        // len=2: one timeout, then the retry keeps the original length
        bus.job_valid = 1'b1; bus.job_len = 4'd2;
        chk_cyc("t3b.push", S_IDLE, 0, 0, 0, 0);
        bus.job_valid = 1'b0;
        chk_cyc("t3b.pop",  S_IDLE, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            chk_cyc($sformatf("t3b.w%0d", i), S_REQ, 0, 0, 8'(i == 14) != 0, 0);
        end
        chk_cyc("t3b.rel", S_REL, 0, 0, 0, 0);
        g_man = 1'b1;
        chk_cyc("t3b.req",  S_REQ,  0, 0, 0, 0);
        chk_cyc("t3b.b1",   S_XFER, 1, 0, 0, 0);
        chk_cyc("t3b.b2",   S_XFER, 1, 1, 0, 0);
        chk_cyc("t3b.rel2", S_REL,  0, 0, 0, 0);
        chk_cyc("t3b.idle", S_IDLE, 0, 0, 0, 0);
        g_man = 1'b0;

        // len=2, no grant: three timeouts, error on the third, job dropped
        bus.job_valid = 1'b1; bus.job_len = 4'd2;
        chk_cyc("t3.push", S_IDLE, 0, 0, 0, 0);
        bus.job_valid = 1'b0;
        chk_cyc("t3.pop",  S_IDLE, 0, 0, 0, 0);
        for (int a = 0; a < 3; a++) begin
            for (int i = 0; i < 15; i++) begin
                chk_cyc($sformatf("t3.a%0d.w%0d", a, i), S_REQ, 0, 0,
                        8'(i == 14) != 0, 8'((a == 2) && (i == 14)) != 0);
            end
            chk_cyc($sformatf("t3.a%0d.rel", a), S_REL, 0, 0, 0, 0);
        end
        chk_cyc("t3.idle0", S_IDLE, 0, 0, 0, 0);
        chk_cyc("t3.idle1", S_IDLE, 0, 0, 0, 0);
        chk("t3.ready", 8'(bus.job_ready), 8'd1);

        // len=4, grant withdrawn for 5 cycles after beat 2
        g_man = 1'b1;
        bus.job_valid = 1'b1; bus.job_len = 4'd4;
        chk_cyc("t4.push", S_IDLE, 0, 0, 0, 0);
        bus.job_valid = 1'b0;
        chk_cyc("t4.pop",  S_IDLE, 0, 0, 0, 0);
        chk_cyc("t4.req",  S_REQ,  0, 0, 0, 0);
        chk_cyc("t4.b1",   S_XFER, 1, 0, 0, 0);
        chk_cyc("t4.b2",   S_XFER, 1, 0, 0, 0);
        g_man = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_cyc($sformatf("t4.stall%0d", i), S_XFER, 0, 0, 0, 0);
        end
        g_man = 1'b1;
        chk_cyc("t4.b3",   S_XFER, 1, 0, 0, 0);
        chk_cyc("t4.b4",   S_XFER, 1, 1, 0, 0);
        chk_cyc("t4.rel",  S_REL,  0, 0, 0, 0);
        chk_cyc("t4.idle", S_IDLE, 0, 0, 0, 0);
        g_man = 1'b0;

        // Hold a len=1 job in REQ, then push 5 more; the 5th (len 7) must be ignored
        bus.job_valid = 1'b1; bus.job_len = 4'd1;
        chk_cyc("t5.push0", S_IDLE, 0, 0, 0, 0);
        bus.job_valid = 1'b0;
        chk_cyc("t5.pop0",  S_IDLE, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            bus.job_valid = 1'b1;
            bus.job_len   = 4'(lens[k]);
            chk($sformatf("t5.ready%0d", k), 8'(bus.job_ready), 8'(k < 4));
            chk_cyc($sformatf("t5.hold%0d", k), S_REQ, 0, 0, 0, 0);
        end
        bus.job_valid = 1'b0;
        chk("t5.full", 8'(bus.job_ready), 8'd0);
        g_man = 1'b1;
        beats = 0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.beat) beats++;
            if (bus.done) dones++;
            @(posedge clk);
            #1;
        end
        // Head job (1 beat) plus the four queued jobs 2+3+4+5
        chk("t5.beats", 8'(beats), 8'd15);
        chk("t5.dones", 8'(dones), 8'd5);
        chk("t5.ready_end", 8'(bus.job_ready), 8'd1);
        chk_cyc("t5.idle", S_IDLE, 0, 0, 0, 0);

        // Reset mid-XFER with a second job queued; both must vanish
        bus.job_valid = 1'b1; bus.job_len = 4'd5;
        chk_cyc("t6.push0", S_IDLE, 0, 0, 0, 0);
        bus.job_len = 4'd1;
        chk_cyc("t6.push1", S_IDLE, 0, 0, 0, 0);
        bus.job_valid = 1'b0;
        chk_cyc("t6.req",   S_REQ,  0, 0, 0, 0);
        chk_cyc("t6.b1",    S_XFER, 1, 0, 0, 0);
        chk_cyc("t6.b2",    S_XFER, 1, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("t6.state", 8'(bus.req_state), 8'(S_IDLE));
        chk("t6.r",     8'(bus.r),         8'd0);
        chk("t6.beat",  8'(bus.beat),      8'd0);
        chk("t6.done",  8'(bus.done),      8'd0);
        chk("t6.busy",  8'(bus.busy),      8'd0);
        chk("t6.ready", 8'(bus.job_ready), 8'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_cyc($sformatf("t6.after%0d", i), S_IDLE, 0, 0, 0, 0);
        end
        g_man = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
